counter_ctrl: RTL
=================

# counter_ctrl

Command front-end that sits directly upstream of the 4-bit loadable binary counter. It turns three raw push-button inputs into clean load and enable strobes, plus preset data, for the counter's `d`/`load`/`en` inputs. It watches the counter's `q` output and stops counting exactly at a programmable target value. It signals completion with a one-cycle `done` pulse.

## Interface
- `N`, default 4: counter width in bits; sets the width of `preset`, `target`, `q` and `d`.
- `DB_CYCLES`, default 4: number of consecutive stable synchronized samples needed before a button level is accepted; must be ≥ 1.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start_btn`, input, 1: raw start/resume button; asynchronous to `clk`.
- `stop_btn`, input, 1: raw pause/abort button; asynchronous to `clk`.
- `load_btn`, input, 1: raw load button; asynchronous to `clk`.
- `preset`, input, N: value to load into the counter.
- `target`, input, N: count value at which counting stops.
- `q`, input, N: counter output, fed back.
- `d`, output, N: drives the counter's `d` input.
- `load`, output, 1: drives the counter's `load` input.
- `en`, output, 1: drives the counter's `en` input.
- `busy`, output, 1: high while in RUN or PAUSE.
- `done`, output, 1: one-cycle pulse when the target is reached.

## Operation
- **Input conditioning.** Each button passes through its own conditioning chain:
  - a 2-flop synchronizer;
  - a debounce counter, which resets whenever the synchronized sample equals the debounced level and increments otherwise;
  - the debounced level flips on the edge where the counter would reach `DB_CYCLES`;
  - a command pulse (`start_cmd`/`stop_cmd`/`load_cmd`), which is high for one cycle after each rising edge of the debounced level.
- **Falling edges and glitches.** Falling edges produce no command. A glitch shorter than `DB_CYCLES` samples produces no command.
- **Simultaneous commands.** When commands arrive in the same cycle, priority is stop > load > start. Only the winning command acts; the others are discarded.
- **FSM states.** IDLE, LOAD, RUN, PAUSE, DONE.
  - **IDLE:** `load_cmd` goes to LOAD. `start_cmd` goes to RUN. `stop_cmd` is ignored.
  - **LOAD:** lasts exactly one cycle with `load`=1, then returns to IDLE.
  - **RUN:** `en` = (`q` != `target`). `stop_cmd` goes to PAUSE. `load_cmd` goes to LOAD, which aborts the run. When `q` == `target` (with no command present), go to DONE.
  - **PAUSE:** `en`=0. `start_cmd` returns to RUN. `load_cmd` goes to LOAD. `stop_cmd` goes to IDLE (abort, with no `done`).
  - **DONE:** lasts one cycle with `done`=1, then goes to IDLE.
- **Preset capture.** `d` is a register. It captures `preset` on the edge where `load_cmd` is accepted (the transition into LOAD) and holds that value until the next accepted load.
- **Output decoding.**
  - `load` is decoded from the registered state.
  - `en` is combinational from the state and `q`, so the counter never counts past `target`.
- **Wrap-around.** If `target` < `q` at start, the counter wraps through 2^N−1 to 0 and continues until it reaches `target`.
- **Start at target.** If `q` == `target` when RUN is entered, `en` stays 0 and the FSM goes to DONE on the next edge (zero counts).
- **Reset.**
  - Outputs: `load`=0, `en`=0, `d`=0, `busy`=0, `done`=0.
  - Internal state: FSM in IDLE, synchronizers, debounced levels and debounce counters all 0.
  - Reset mid-run returns to IDLE immediately, with no `done`.
  - A button held high through reset is recognized as a new press after debouncing once reset is released.

## Timing
- **Button latency.** A raw level that is stable from before edge 0 gives:
  - synchronized level at edge 2;
  - debounced flip at edge 2+`DB_CYCLES`;
  - command pulse high during the cycle after edge 2+`DB_CYCLES`;
  - FSM acts at edge 3+`DB_CYCLES`.
- **Load.** `load` is high during exactly one cycle, the one following the edge where the FSM enters LOAD. `d` is valid in that same cycle. The counter therefore shows `preset` on `q` one edge later.
- **Counting.** In RUN, the counter increments every edge while `q` != `target`. `done` is high in the cycle after the cycle in which `q` first equals `target`.
- **Stop.** `en` drops in the same cycle in which the FSM enters PAUSE, so exactly the counts made before that edge are kept.

## Test plan (N=4, DB_CYCLES=4)
- Reset held 3 cycles with all buttons low → every output 0 and the FSM in IDLE; `q` is unchanged by this block.
- `preset`=4'b1010, `load_btn` pulsed high for 10 cycles → exactly one `load` pulse, at the 8th edge after the press; `d`=4'b1010; counter `q`=4'b1010 one edge later.
- After that load, `target`=4'b0011, start pressed → `en` high for 9 edges as `q` goes 1011…1111, 0000…0011 (wrap-around); `q` holds at 0011; one `done` pulse; `busy` falls.
- `start_btn` glitch of 3 cycles, then `stop_btn` glitch of 2 cycles → no command; state stays IDLE; `en` stays 0.
- During RUN with `q`=0101, stop pressed → `en`=0 and `q` holds. Start pressed → counting resumes from the held value. Stop pressed twice → the second stop goes to IDLE with no `done`.
- Start and stop released to the debouncer in the same cycle while in IDLE → stop wins, so no RUN. `reset` asserted mid-RUN → `en`=0 on the next cycle and no `done`.

Source files
------------

// File: rtl/counter_ctrl.sv
// counter_ctrl: push-button front-end for a loadable binary counter.
// Conditions three raw buttons into clean command pulses, sequences
// load/run/pause through a small FSM, and stops the counter exactly at
// a programmable target, announcing completion with a one-cycle done pulse.
module counter_ctrl #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_btn,
    input  logic         stop_btn,
    input  logic         load_btn,
    input  logic [N-1:0] preset,
    input  logic [N-1:0] target,
    input  logic [N-1:0] q,
    output logic [N-1:0] d,
    output logic         load,
    output logic         en,
    output logic         busy,
    output logic         done
);

    // Button lane indices inside the packed conditioning vectors.
    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LOAD  = 2;
    localparam int NBTN      = 3;

    // Debounce counter only needs to reach DB_CYCLES-1 before the level flips.
    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q, sync1_d;
    logic [NBTN-1:0] sync2_q, sync2_d;
    logic [NBTN-1:0] level_q, level_d;
    logic [NBTN-1:0] cmd_q, cmd_d;
    logic [CW-1:0]   cnt_q [NBTN];
    logic [CW-1:0]   cnt_d [NBTN];

    state_t          state_q, state_d;
    logic [N-1:0]    d_q, d_d;

    logic            start_cmd;
    logic            stop_cmd;
    logic            load_cmd;
    logic            at_target;

    assign btn_raw   = {load_btn, stop_btn, start_btn};
    assign start_cmd = cmd_q[BTN_START];
    assign stop_cmd  = cmd_q[BTN_STOP];
    assign load_cmd  = cmd_q[BTN_LOAD];
    assign at_target = (q == target);

    // Synchronize, debounce and edge-detect each button independently.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cmd_d   = '0;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                // This sample would make DB_CYCLES in a row: accept the new level.
                cnt_d[i]   = '0;
                level_d[i] = ~level_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
            // Only rising edges of the accepted level become commands.
            cmd_d[i] = level_d[i] & ~level_q[i];
        end
    end

    // Next-state logic with stop > load > start priority; losers are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (stop_cmd)       state_d = S_IDLE;
                else if (load_cmd)  state_d = S_LOAD;
                else if (start_cmd) state_d = S_RUN;
            end
            S_LOAD: state_d = S_IDLE;
            S_RUN: begin
                if (stop_cmd)                   state_d = S_PAUSE;
                else if (load_cmd)              state_d = S_LOAD;
                else if (!start_cmd && at_target) state_d = S_DONE;
            end
            S_PAUSE: begin
                if (stop_cmd)       state_d = S_IDLE;
                else if (load_cmd)  state_d = S_LOAD;
                else if (start_cmd) state_d = S_RUN;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Preset is captured only on the edge that accepts a load command.
    always_comb begin
        d_d = d_q;
        if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
            d_d = preset;
        end
    end

    // All control state: conditioning chains, FSM and preset register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            cmd_q   <= '0;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= S_IDLE;
            d_q     <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cmd_q   <= cmd_d;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            d_q     <= d_d;
        end
    end

    // en is combinational on q so the counter can never step past target.
    assign d    = d_q;
    assign load = (state_q == S_LOAD);
    assign en   = (state_q == S_RUN) && !at_target;
    assign busy = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done = (state_q == S_DONE);

endmodule
